tc_pipe_ctrl: RTL and testbench

// - Parametrised handshake controller for the 4x4 transform-coding chain:

---
 rtl/tc_pipe_ctrl_if.sv | 29 ++
 rtl/tc_pipe_ctrl.sv | 96 +++++++++
 tb/tb_tc_pipe_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/tc_pipe_ctrl_if.sv
// Block handshake between the residual source / output sink and tc_pipe_ctrl.
// Valid/ready: a transfer happens on a rising edge where valid and ready are
// both high; the payload (in_qp, in_mode) is only meaningful while in_valid is high.
interface tc_pipe_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_qp;
  logic       in_mode;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_valid,
    output in_qp,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  in_qp,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output out_valid
  );
endinterface

// File: rtl/tc_pipe_ctrl.sv
// Valid/ready controller for the tran -> quant -> invquant -> invtran chain.
// Each slot carries a valid bit and a per-block QP/mode token; stalls are global.
module tc_pipe_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int QP_MAX     = 51,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  tc_pipe_ctrl_if.slave           hs,
  input  logic                    flush,
  output logic [NUM_STAGES-1:0]   stage_en,
  output logic [4*NUM_STAGES-1:0] stage_qp_by_6,
  output logic [3*NUM_STAGES-1:0] stage_qp_mod_6,
  output logic [NUM_STAGES-1:0]   stage_mode,
  output logic                    pipeline_full,
  output logic                    busy,
  output logic                    qp_clamped,
  output logic [CNT_W-1:0]        block_count
);

  localparam logic [5:0] QP_MAX_L = 6'(QP_MAX);

  logic [NUM_STAGES-1:0] v;
  logic [3:0]            qpd [NUM_STAGES];
  logic [2:0]            qpm [NUM_STAGES];
  logic                  md  [NUM_STAGES];

  logic       stall;
  logic       advance;
  logic       accept;
  logic       over_max;
  logic [5:0] q;
  logic [3:0] qpd_in;
  logic [2:0] qpm_in;

  assign stall    = v[NUM_STAGES-1] & ~hs.out_ready;
  assign advance  = ~stall & ~flush & ~reset;
  assign accept   = hs.in_valid & advance;
  assign over_max = hs.in_qp > QP_MAX_L;
  assign q        = over_max ? QP_MAX_L : hs.in_qp;
  assign qpd_in   = 4'(q / 6'd6);
  assign qpm_in   = 3'(q % 6'd6);

  assign hs.in_ready  = advance;
  assign hs.out_valid = v[NUM_STAGES-1];
  assign pipeline_full = &v;
  assign busy          = |v;

  always_comb begin
    stage_en       = '0;
    stage_qp_by_6  = '0;
    stage_qp_mod_6 = '0;
    stage_mode     = '0;
    stage_en[0]    = accept;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (i > 0) stage_en[i] = advance & v[i-1];
      stage_qp_by_6[4*i +: 4]  = qpd[i];
      stage_qp_mod_6[3*i +: 3] = qpm[i];
      stage_mode[i]            = md[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v           <= '0;
      block_count <= '0;
      qp_clamped  <= 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        qpd[i] <= '0;
        qpm[i] <= '0;
        md[i]  <= 1'b0;
      end
    end else begin
      // accept is already low while flushing or stalling, so no extra gating here
      qp_clamped <= accept & over_max;
      if (hs.out_ready & v[NUM_STAGES-1] & ~flush)
        block_count <= block_count + CNT_W'(1);
      if (flush) begin
        v <= '0;
      end else if (advance) begin
        // Slot 0 always reloads, so an idle input cycle becomes a bubble
        v      <= {v[NUM_STAGES-2:0], accept};
        qpd[0] <= qpd_in;
        qpm[0] <= qpm_in;
        md[0]  <= hs.in_mode;
        for (int i = 1; i < NUM_STAGES; i++) begin
          qpd[i] <= qpd[i-1];
          qpm[i] <= qpm[i-1];
          md[i]  <= md[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_tc_pipe_ctrl.sv
// Bench for tc_pipe_ctrl: directed scenarios then random traffic, all checked
// against a queue-based model of block tokens moving through the slots.
module tb_tc_pipe_ctrl;
  localparam int NS  = 4;
  localparam int QPM = 51;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic flush;
  always #5 clk = ~clk;

  tc_pipe_ctrl_if hs ();
  tc_pipe_ctrl_if hs2 ();

  logic [NS-1:0]   stage_en, stage_en_2;
  logic [4*NS-1:0] stage_qp_by_6, stage_qp_by_6_2;
  logic [3*NS-1:0] stage_qp_mod_6, stage_qp_mod_6_2;
  logic [NS-1:0]   stage_mode, stage_mode_2;
  logic            pipeline_full, pipeline_full_2;
  logic            busy, busy_2;
  logic            qp_clamped, qp_clamped_2;
  logic [15:0]     block_count;
  logic [1:0]      block_count_2;

  tc_pipe_ctrl #(.NUM_STAGES(NS), .QP_MAX(QPM), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .hs(hs.slave), .flush(flush),
    .stage_en(stage_en), .stage_qp_by_6(stage_qp_by_6), .stage_qp_mod_6(stage_qp_mod_6),
    .stage_mode(stage_mode), .pipeline_full(pipeline_full), .busy(busy),
    .qp_clamped(qp_clamped), .block_count(block_count)
  );

  tc_pipe_ctrl #(.NUM_STAGES(NS), .QP_MAX(QPM), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .hs(hs2.slave), .flush(flush),
    .stage_en(stage_en_2), .stage_qp_by_6(stage_qp_by_6_2), .stage_qp_mod_6(stage_qp_mod_6_2),
    .stage_mode(stage_mode_2), .pipeline_full(pipeline_full_2), .busy(busy_2),
    .qp_clamped(qp_clamped_2), .block_count(block_count_2)
  );

  // reference model: one entry per slot, index 0 = youngest
  typedef struct packed {
    logic       v;
    logic [3:0] qpd;
    logic [2:0] qpm;
    logic       md;
  } slot_t;

  slot_t      pipe[$];
  logic [7:0] exp_q[$];
  int         m_total;
  logic       m_clamped;
  bit         known;
  int         n_checks;
  int         n_errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] tok_of(input int qp, input bit md);
    int q;
    q = (qp > QPM) ? QPM : qp;
    return {4'(q / 6), 3'(q % 6), md};
  endfunction

  function automatic logic [7:0] dut_tok(input int i);
    return {stage_qp_by_6[4*i +: 4], stage_qp_mod_6[3*i +: 3], stage_mode[i]};
  endfunction

  // driver: apply one cycle of inputs, check against the model, clock, update model
  task automatic step(input bit iv, input int qp, input bit md, input bit fl,
                      input bit ordy, input bit rst);
    bit            stall, adv, acc, any, all, out_hs;
    logic [NS-1:0] exp_en;
    logic [7:0]    e, t;
    slot_t         s;
    hs.in_valid  = iv;  hs.in_qp  = 6'(qp); hs.in_mode  = md; hs.out_ready  = ordy;
    hs2.in_valid = iv;  hs2.in_qp = 6'(qp); hs2.in_mode = md; hs2.out_ready = ordy;
    flush = fl;
    reset = rst;
    #2;
    stall  = pipe[NS-1].v && !ordy;
    adv    = !stall && !fl && !rst;
    acc    = iv && adv;
    out_hs = pipe[NS-1].v && ordy && !fl && !rst;
    if (known) begin
      exp_en[0] = acc;
      any = 1'b0;
      all = 1'b1;
      for (int i = 0; i < NS; i++) begin
        if (i > 0) exp_en[i] = adv && pipe[i-1].v;
        any |= pipe[i].v;
        all &= pipe[i].v;
      end
      check_eq("in_ready", 32'(hs.in_ready), 32'(adv));
      check_eq("stage_en", 32'(stage_en), 32'(exp_en));
      check_eq("out_valid", 32'(hs.out_valid), 32'(pipe[NS-1].v));
      check_eq("busy", 32'(busy), 32'(any));
      check_eq("pipeline_full", 32'(pipeline_full), 32'(all));
      check_eq("qp_clamped", 32'(qp_clamped), 32'(m_clamped));
      check_eq("block_count", 32'(block_count), 32'(m_total % 65536));
      check_eq("block_count_w2", 32'(block_count_2), 32'(m_total % 4));
      for (int i = 0; i < NS; i++) begin
        if (pipe[i].v) begin
          check_eq($sformatf("slot%0d_token", i), 32'(dut_tok(i)),
                   32'({pipe[i].qpd, pipe[i].qpm, pipe[i].md}));
        end
      end
      if (out_hs && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = dut_tok(NS-1);
        check_eq("output_order", 32'(t), 32'(e));
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      foreach (pipe[i]) pipe[i] = '0;
      exp_q.delete();
      m_total   = 0;
      m_clamped = 1'b0;
      known     = 1'b1;
    end else if (fl) begin
      foreach (pipe[i]) pipe[i].v = 1'b0;
      exp_q.delete();
      m_clamped = 1'b0;
    end else if (adv) begin
      if (out_hs) m_total++;
      void'(pipe.pop_back());
      e = tok_of(qp, md);
      s = {acc, e};
      pipe.push_front(s);
      if (acc) exp_q.push_back(e);
      m_clamped = acc && (qp > QPM);
    end else begin
      m_clamped = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_total  = 0;
    m_clamped = 1'b0;
    known    = 1'b0;
    for (int i = 0; i < NS; i++) pipe.push_back('0);

    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("reset_count", 32'(block_count), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);

    // single block QP=28, mode=1
    step(1'b1, 28, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("t1_slot0_token", 32'(dut_tok(0)), 32'({4'd4, 3'd4, 1'b1}));
    idle(4);
    check_eq("t1_count", 32'(block_count), 32'd1);

    // eight back-to-back blocks
    for (int q = 0; q < 8; q++) step(1'b1, q, 1'(q), 1'b0, 1'b1, 1'b0);
    idle(4);
    check_eq("t2_count", 32'(block_count), 32'd9);

    // full pipe held by back-pressure, then drained
    for (int i = 0; i < NS; i++) step(1'b1, $urandom_range(0, 63), 1'($urandom), 1'b0, 1'b1, 1'b0);
    check_eq("t3_full", 32'(pipeline_full), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 9, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(NS + 1);

    // clamping
    step(1'b1, 60, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("t4_clamp_pulse", 32'(qp_clamped), 32'd1);
    check_eq("t4_clamp_token", 32'(dut_tok(0)), 32'({4'd8, 3'd3, 1'b0}));
    step(1'b1, 51, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("t4_max_no_pulse", 32'(qp_clamped), 32'd0);
    check_eq("t4_max_token", 32'(dut_tok(0)), 32'({4'd8, 3'd3, 1'b0}));
    idle(NS);

    // flush with three in flight
    for (int i = 0; i < 3; i++) step(1'b1, 12 + i, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("t5_busy_after_flush", 32'(busy), 32'd0);
    idle(2);

    // reset mid-stream, then wrap of the 2-bit counter
    for (int i = 0; i < 2; i++) step(1'b1, 30, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 30, 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("t6_count_reset", 32'(block_count), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 40 + i, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(NS);
    check_eq("t6_count", 32'(block_count), 32'd5);
    check_eq("t6_count_w2", 32'(block_count_2), 32'd1);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 9) < 7), $urandom_range(0, 63), 1'($urandom),
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 99) == 0));
    end
    idle(NS + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
